// File: rtl/l1_ahb_cmd_master.sv
// AHB-Lite initiator: turns a command/write-data stream into SINGLE/INCR
// transfers and returns one response per completed beat.
module l1_ahb_cmd_master #(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int LENW = 4
) (
    input  logic            HCLK,
    input  logic            HRESET,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [AW-1:0]   cmd_addr,
    input  logic            cmd_write,
    input  logic [2:0]      cmd_size,
    input  logic [LENW-1:0] cmd_len,
    input  logic            wd_valid,
    output logic            wd_ready,
    input  logic [DW-1:0]   wd_data,
    output logic            rsp_valid,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_err,
    output logic            rsp_last,
    output logic [AW-1:0]   HADDR,
    output logic [1:0]      HTRANS,
    output logic            HWRITE,
    output logic [2:0]      HSIZE,
    output logic [2:0]      HBURST,
    output logic [3:0]      HPROT,
    output logic [DW-1:0]   HWDATA,
    input  logic [DW-1:0]   HRDATA,
    input  logic            HREADY,
    input  logic [1:0]      HRESP
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DRAIN, S_ERR} state_t;

    localparam logic [1:0]  TR_IDLE = 2'b00;
    localparam logic [1:0]  TR_BUSY = 2'b01;
    localparam logic [1:0]  TR_NSEQ = 2'b10;
    localparam logic [1:0]  TR_SEQ  = 2'b11;
    localparam logic [LENW:0] ONE   = 1;

    state_t          state_q;
    logic [AW-1:0]   haddr_q, addr_q;
    logic [1:0]      htrans_q;
    logic            hwrite_q;
    logic [2:0]      hsize_q, hburst_q;
    logic [3:0]      hprot_q;
    logic [DW-1:0]   hwdata_q, wbuf_q;
    logic [LENW:0]   left_q;
    logic            first_q;
    logic            dp_q, dp_last_q, dp_wr_q;
    logic            rsp_valid_q, rsp_err_q, rsp_last_q;
    logic [DW-1:0]   rsp_rdata_q;

    logic            acc, due, err_now, issue;
    logic            beat_first, beat_wr;
    logic [AW-1:0]   beat_addr, inc;
    logic [LENW:0]   beat_left;

    assign cmd_ready = (state_q == S_IDLE) && !dp_q && !HRESET;

    // The first beat is launched on the same edge that accepts the command.
    always_comb begin
        acc        = cmd_valid && cmd_ready;
        beat_addr  = acc ? cmd_addr : addr_q;
        beat_wr    = acc ? cmd_write : hwrite_q;
        beat_first = acc || first_q;
        beat_left  = acc ? ({1'b0, cmd_len} + ONE) : left_q;
        inc        = AW'(1) << (acc ? cmd_size : hsize_q);
        due        = acc || (state_q == S_ADDR && left_q != '0);
        err_now    = dp_q && (HRESP != 2'b00);
        issue      = due && HREADY && !HRESET && !err_now
                     && (!beat_wr || wd_valid);
    end

    assign wd_ready = issue && beat_wr;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= S_IDLE;
            haddr_q     <= '0;
            addr_q      <= '0;
            htrans_q    <= TR_IDLE;
            hwrite_q    <= 1'b0;
            hsize_q     <= '0;
            hburst_q    <= '0;
            hprot_q     <= '0;
            hwdata_q    <= '0;
            wbuf_q      <= '0;
            left_q      <= '0;
            first_q     <= 1'b0;
            dp_q        <= 1'b0;
            dp_last_q   <= 1'b0;
            dp_wr_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (acc) begin
                state_q  <= S_ADDR;
                hwrite_q <= cmd_write;
                hsize_q  <= cmd_size;
                hburst_q <= (cmd_len == '0) ? 3'b000 : 3'b001;
                hprot_q  <= 4'b0011;
                addr_q   <= cmd_addr;
                left_q   <= beat_left;
                first_q  <= 1'b1;
            end
            if (err_now && !HREADY) begin
                // first error cycle: cancel any pending address phase
                htrans_q <= TR_IDLE;
                state_q  <= S_ERR;
            end else if ((state_q == S_ERR || err_now) && HREADY) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b1;
                rsp_last_q  <= 1'b1;
                rsp_rdata_q <= '0;
                dp_q        <= 1'b0;
                htrans_q    <= TR_IDLE;
                state_q     <= S_IDLE;
            end else if (HREADY) begin
                if (dp_q) begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_last_q  <= dp_last_q;
                    rsp_rdata_q <= dp_wr_q ? '0 : HRDATA;
                end
                dp_q <= htrans_q[1];
                if (htrans_q[1]) begin
                    dp_last_q <= (left_q == '0);
                    dp_wr_q   <= hwrite_q;
                    if (hwrite_q)
                        hwdata_q <= wbuf_q;
                end
                if (issue) begin
                    haddr_q  <= beat_addr;
                    htrans_q <= (beat_first || beat_addr[9:0] == '0)
                                ? TR_NSEQ : TR_SEQ;
                    addr_q   <= beat_addr + inc;
                    left_q   <= beat_left - ONE;
                    first_q  <= 1'b0;
                    if (beat_wr)
                        wbuf_q <= wd_data;
                end else if (due) begin
                    // write data late: BUSY mid-burst, IDLE before first beat
                    htrans_q <= beat_first ? TR_IDLE : TR_BUSY;
                    if (!beat_first)
                        haddr_q <= beat_addr;
                end else begin
                    htrans_q <= TR_IDLE;
                end
                if (state_q == S_ADDR && left_q == '0)
                    state_q <= S_DRAIN;
                if (state_q == S_DRAIN && dp_q)
                    state_q <= S_IDLE;
            end
        end
    end

    assign HADDR     = haddr_q;
    assign HTRANS    = htrans_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HBURST    = hburst_q;
    assign HPROT     = hprot_q;
    assign HWDATA    = hwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_last  = rsp_last_q;

endmodule

// File: doc/l1_ahb_cmd_master.md
Name: l1_ahb_cmd_master

Overview:
AHB-Lite initiator that turns a simple command interface into single or INCR transfers on the L1 matrix slave ports. It is the initiator counterpart to the matrix's default slave. It must handle wait states, BUSY insertion and the two-cycle ERROR response exactly as a default slave produces them. Each command generates a stream of per-beat responses (read data or error) back to the local client.

Parameters:
AW, 32, address width
DW, 32, data width (HSIZE must not exceed DW)
LENW, 4, command length field width; a burst is at most 2^LENW beats

Ports:
HCLK  in  1  AHB clock
HRESET  in  1  synchronous reset, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when valid&ready
cmd_addr  in  AW  start address, aligned to cmd_size
cmd_write  in  1  1 = write, 0 = read
cmd_size  in  3  HSIZE value for all beats
cmd_len  in  LENW  beats minus 1
wd_valid  in  1  write beat data available
wd_ready  out  1  write beat consumed
wd_data  in  DW  write beat data
rsp_valid  out  1  one beat completed (no backpressure)
rsp_rdata  out  DW  read data (0 for writes)
rsp_err  out  1  beat ended in ERROR
rsp_last  out  1  final response of the command
HADDR  out  AW  address
HTRANS  out  2  IDLE 00, BUSY 01, NONSEQ 10, SEQ 11
HWRITE  out  1  direction
HSIZE  out  3  size
HBURST  out  3  000 SINGLE when len==0, else 001 INCR
HPROT  out  4  constant 4'b0011
HWDATA  out  DW  write data (data phase)
HRDATA  in  DW  read data
HREADY  in  1  transfer done
HRESP  in  2  00 OKAY; any non-zero value is treated as ERROR

Behaviour:
- All AHB outputs are registered.
- Reset state, effective at the first HCLK edge with HRESET high, including mid-burst: HTRANS=IDLE, all other outputs 0, state IDLE. In-flight beats are dropped and produce no response.
- States:
  - IDLE: cmd_ready=1 only here, and only when no data phase is outstanding. Accepting a command moves to ADDR.
  - ADDR: issue address phases. After the last beat's address phase is accepted, move to DRAIN.
  - DRAIN: wait for the final data phase to complete, then return to IDLE.
  - ERR: second cycle of an error response, then IDLE.
- Address phase acceptance: HREADY=1 at an edge while HTRANS is NONSEQ or SEQ. Outputs hold stable while HREADY=0.
- Beat types:
  - First beat is NONSEQ. Later beats are SEQ.
  - A beat whose address crosses a 1KB boundary (addr[9:0]==0) is re-issued as NONSEQ with identical HBURST.
  - Address increments by 1<<cmd_size, modulo 2^AW.
- Writes:
  - A beat's address phase is issued only when wd_valid=1. wd_ready pulses for exactly the accepted beat, and wd_data is captured then.
  - HWDATA is driven from the capture register during that beat's data phase.
  - If wd_valid=0 when the next beat is due: mid-burst, drive BUSY with HADDR = next beat address (not a beat, no response); on the first beat, hold IDLE.
- Responses:
  - One response per beat, registered: rsp_valid asserts the cycle after the beat's data phase completes (HREADY=1, HRESP=OKAY).
  - rsp_rdata is HRDATA captured at that edge.
  - rsp_last=1 on the final beat.
- ERROR handling:
  - Cycle 1 (HRESP!=0, HREADY=0): at that edge, HTRANS is forced to IDLE so any pending next-beat address is cancelled. Enter ERR.
  - Cycle 2 (HREADY=1): emit a response with rsp_err=1, rsp_last=1. Remaining beats are abandoned, then IDLE.
  - If wd_ready was already pulsed for the cancelled beat, that data is discarded.
- Back-to-back commands have a minimum one-cycle IDLE on HTRANS between them.
- Zero-wait throughput: one beat per cycle.

Test Plan:
1. Single write, addr 0x100, size 2, len 0, wd ready, HREADY=1 always -> NONSEQ/SINGLE at cycle 1, HWDATA at cycle 2, rsp_valid cycle 3 with err=0, last=1.
2. 4-beat read from 0x200 with 2 wait states on beat 2 -> HADDR 0x200, 0x204, 0x208, 0x20C, SEQ held during waits, 4 responses in order, last on the 4th.
3. 3-beat write with wd_valid low for 2 cycles before beat 2 -> two BUSY cycles at HADDR 0x004, then SEQ. No response is generated for the BUSY cycles.
4. 4-beat read where the slave returns ERROR on beat 2 (HREADY=0/HRESP=01, then HREADY=1/HRESP=01) -> HTRANS IDLE in error cycle 2. Responses: beat 1 OK, beat 2 err=1/last=1, nothing further.
5. 4-beat word read from 0x3F8 -> beats 0x3F8 NONSEQ, 0x3FC SEQ, 0x400 NONSEQ, 0x404 SEQ.
6. HRESET asserted during beat 3 of 8 -> next edge HTRANS=IDLE, rsp_valid=0, cmd_ready=1 after release, and a new command executes normally.
